// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative HI/LO divider.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_BPC   = 1;
    localparam int DIV_N     = DIV_WIDTH / DIV_BPC;

    // Iteration counter width; never collapses to zero bits when N == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on a {rem, quo} pair.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // rem < divisor on entry, so bit WIDTH of the trial is its sign.
    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, i_divisor};

    assign o_rem = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU; result is {remainder, quotient}.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int BPC   = DIV_BPC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               isSigned,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic               divZero,
    output logic [2*WIDTH-1:0] dataOut
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = cnt_width(N);

    div_state_t         r_state, w_next;
    logic [WIDTH-1:0]   r_rem, r_quo, r_div;
    logic [CW-1:0]      r_cnt;
    logic               r_negQ, r_negR, r_zero;
    logic               r_divZero;
    logic [2*WIDTH-1:0] r_dataOut;

    logic               w_aNeg, w_bNeg, w_bZero;
    logic [WIDTH-1:0]   w_absA, w_absB;
    logic [WIDTH-1:0]   w_rem [0:BPC];
    logic [WIDTH-1:0]   w_quo [0:BPC];

    assign w_aNeg  = isSigned & dataA[WIDTH-1];
    assign w_bNeg  = isSigned & dataB[WIDTH-1];
    assign w_absA  = w_aNeg ? -dataA : dataA;
    assign w_absB  = w_bNeg ? -dataB : dataB;
    assign w_bZero = (dataB == '0);

    assign w_rem[0] = r_rem;
    assign w_quo[0] = r_quo;

    for (genvar g = 0; g < BPC; g++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .i_rem     (w_rem[g]),
            .i_quo     (w_quo[g]),
            .i_divisor (r_div),
            .o_rem     (w_rem[g+1]),
            .o_quo     (w_quo[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = w_bZero ? ST_FIX : ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == '0) w_next = ST_FIX;
            end
            ST_FIX: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Divide-by-zero preloads the final {dataA, all-ones} with no sign fix,
    // so FIX handles both paths identically.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_zero    <= 1'b0;
            r_divZero <= 1'b0;
            r_dataOut <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_div <= w_absB;
                    r_cnt <= CW'(N - 1);
                    if (w_bZero) begin
                        r_rem  <= dataA;
                        r_quo  <= '1;
                        r_negQ <= 1'b0;
                        r_negR <= 1'b0;
                        r_zero <= 1'b1;
                    end else begin
                        r_rem  <= '0;
                        r_quo  <= w_absA;
                        r_negQ <= w_aNeg ^ w_bNeg;
                        r_negR <= w_aNeg;
                        r_zero <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem[BPC];
                    r_quo <= w_quo[BPC];
                    r_cnt <= r_cnt - CW'(1);
                end
                ST_FIX: begin
                    r_dataOut <= {(r_negR ? -r_rem : r_rem), (r_negQ ? -r_quo : r_quo)};
                    r_divZero <= r_zero;
                end
                default: ;
            endcase
        end
    end

    assign dataOut = r_dataOut;
    assign divZero = r_divZero;

endmodule
